// File: rtl/audio_pkg.sv
// Shared constants and slot-formatting helper for the serial-audio transmitter.
package audio_pkg;

    localparam int unsigned MODE_I2S   = 0;
    localparam int unsigned MODE_LJ    = 1;
    localparam int unsigned MODE_RJ    = 2;
    localparam int unsigned MAX_SLOT_W = 64;

    // Returns a slot with slot bit k at position slot_w-1-k, so the slot shifts out MSB first.
    // The sample arrives zero-extended; bits outside the sample window stay zero.
    function automatic logic [MAX_SLOT_W-1:0] build_slot(
        input logic [MAX_SLOT_W-1:0] sample,
        input int unsigned           sample_w,
        input int unsigned           slot_w,
        input int unsigned           mode
    );
        int unsigned ofs;
        case (mode)
            MODE_I2S: ofs = 1;
            MODE_LJ:  ofs = 0;
            default:  ofs = slot_w - sample_w;
        endcase
        return sample << (slot_w - ofs - sample_w);
    endfunction

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock divider: bclk toggles every BCLK_DIV sys_clk cycles; fall marks the cycle
// whose closing edge drives bclk from 1 to 0.
module bclk_gen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic reset,
    output logic bclk,
    output logic fall
);

    localparam int unsigned     DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             tc;

    // NOTE: every signal written here gets its default on the first lines, so no latch can form.
    always_comb begin
        tc        = (div_cnt_q == DIV_LAST);
        div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
        bclk_d    = tc ? ~bclk_q : bclk_q;
    end

    // NOTE: state updates use <= only, so every flop samples the pre-edge values of the others.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk = bclk_q;
    assign fall = tc & bclk_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo serial-audio transmitter: one-frame holding buffer, frame builder and
// shift register producing bclk/daclrc/dacdat on sys_clk only.
module i2s_tx_serializer
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W      = 24,
    parameter int unsigned SLOT_W        = 32,
    parameter int unsigned BCLK_DIV      = 4,
    parameter int unsigned MODE          = 0,
    parameter int unsigned UNDERRUN_ZERO = 0
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                bclk,
    output logic                daclrc,
    output logic                dacdat,
    output logic                frame_start,
    output logic                underrun
);

    localparam int unsigned       FRAME_W    = 2 * SLOT_W;
    localparam int unsigned       CNT_W      = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  SLOT_START = CNT_W'(SLOT_W);

    if (MODE > 2) begin : g_bad_mode
        $error("i2s_tx_serializer: MODE must be 0, 1 or 2");
    end
    if (SAMPLE_W > SLOT_W) begin : g_bad_width
        $error("i2s_tx_serializer: SAMPLE_W exceeds SLOT_W");
    end
    if (MODE == MODE_I2S && SAMPLE_W > SLOT_W - 1) begin : g_bad_i2s
        $error("i2s_tx_serializer: I2S needs SAMPLE_W <= SLOT_W-1");
    end
    if (BCLK_DIV < 1) begin : g_bad_div
        $error("i2s_tx_serializer: BCLK_DIV must be at least 1");
    end
    if (SLOT_W > MAX_SLOT_W) begin : g_bad_slot
        $error("i2s_tx_serializer: SLOT_W exceeds MAX_SLOT_W");
    end

    logic fall;

    bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bclk    (bclk),
        .fall    (fall)
    );

    logic [2*SAMPLE_W-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [FRAME_W-1:0]    shift_q, shift_d;
    logic [FRAME_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  dacdat_q, dacdat_d;
    logic                  daclrc_q, daclrc_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;

    logic [FRAME_W-1:0]    frame_new;
    logic [FRAME_W-1:0]    shift_src;
    logic                  accept;
    logic                  load;

    always_comb begin
        frame_new = {SLOT_W'(build_slot(MAX_SLOT_W'(hold_q[2*SAMPLE_W-1 -: SAMPLE_W]),
                                        SAMPLE_W, SLOT_W, MODE)),
                     SLOT_W'(build_slot(MAX_SLOT_W'(hold_q[SAMPLE_W-1:0]),
                                        SAMPLE_W, SLOT_W, MODE))};
        accept        = s_valid && !hold_full_q;
        load          = fall && (bit_cnt_q == '0);

        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        shift_d       = shift_q;
        last_d        = last_q;
        bit_cnt_d     = bit_cnt_q;
        dacdat_d      = dacdat_q;
        daclrc_d      = daclrc_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        shift_src     = shift_q;

        // Accept only ever happens with hold empty, so it never collides with a full-hold load.
        if (accept) begin
            hold_d      = {s_left, s_right};
            hold_full_d = 1'b1;
        end

        if (fall) begin
            if (load) begin
                frame_start_d = 1'b1;
                if (hold_full_q) begin
                    shift_src   = frame_new;
                    last_d      = frame_new;
                    hold_full_d = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                    shift_src  = (UNDERRUN_ZERO != 0) ? '0 : last_q;
                end
            end
            dacdat_d  = shift_src[FRAME_W-1];
            shift_d   = {shift_src[FRAME_W-2:0], 1'b0};
            daclrc_d  = (bit_cnt_q >= SLOT_START);
            bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            shift_q       <= '0;
            last_q        <= '0;
            bit_cnt_q     <= '0;
            dacdat_q      <= 1'b0;
            daclrc_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            shift_q       <= shift_d;
            last_q        <= last_d;
            bit_cnt_q     <= bit_cnt_d;
            dacdat_q      <= dacdat_d;
            daclrc_q      <= daclrc_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign s_ready     = ~hold_full_q;
    assign dacdat      = dacdat_q;
    assign daclrc      = daclrc_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: three configurations (I2S, LJ with zero-fill, RJ) share one
// stimulus stream; every cycle each output is compared with an arithmetic frame/bit model.
module tb_i2s_tx_serializer;

    localparam int SW       = 24;
    localparam int SL       = 32;
    localparam int BD       = 2;
    localparam int FB       = 2 * SL;
    localparam int FALL_CYC = 2 * BD;
    localparam int FRAME    = FB * FALL_CYC;

    logic          sys_clk = 1'b0;
    logic          reset   = 1'b1;
    logic          s_valid = 1'b0;
    logic [SW-1:0] s_left  = '0;
    logic [SW-1:0] s_right = '0;

    logic [2:0] rdy, bclk_o, lrc, dat, fs, ur;

    always #5 sys_clk = ~sys_clk;

    i2s_tx_serializer #(.SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(BD), .MODE(0), .UNDERRUN_ZERO(0)) u_i2s (
        .sys_clk(sys_clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy[0]),
        .s_left(s_left), .s_right(s_right), .bclk(bclk_o[0]), .daclrc(lrc[0]),
        .dacdat(dat[0]), .frame_start(fs[0]), .underrun(ur[0]));

    i2s_tx_serializer #(.SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(BD), .MODE(1), .UNDERRUN_ZERO(1)) u_lj (
        .sys_clk(sys_clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy[1]),
        .s_left(s_left), .s_right(s_right), .bclk(bclk_o[1]), .daclrc(lrc[1]),
        .dacdat(dat[1]), .frame_start(fs[1]), .underrun(ur[1]));

    i2s_tx_serializer #(.SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(BD), .MODE(2), .UNDERRUN_ZERO(0)) u_rj (
        .sys_clk(sys_clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy[2]),
        .s_left(s_left), .s_right(s_right), .bclk(bclk_o[2]), .daclrc(lrc[2]),
        .dacdat(dat[2]), .frame_start(fs[2]), .underrun(ur[2]));

    // Reference model: k counts edges since reset release; bclk falls every FALL_CYC edges
    // and every FB-th fall (starting with the first) is a frame load.
    int            k = 0;
    bit            m_full = 0;
    logic [SW-1:0] h_l = '0, h_r = '0, last_l = '0, last_r = '0;
    logic [SW-1:0] rep_l = '0, rep_r = '0, zro_l = '0, zro_r = '0;
    bit            exp_fs = 0, exp_ur = 0, acc_evt = 0, mon_en = 0;
    bit            ld, acc;
    int            n_cmp = 0, n_bad = 0;

    function automatic bit is_load(input int kk);
        return (kk > 0) && (kk % FALL_CYC == 0) && (((kk / FALL_CYC) - 1) % FB == 0);
    endfunction

    always @(posedge sys_clk) begin
        if (reset) begin
            k = 0; m_full = 0; h_l = '0; h_r = '0; last_l = '0; last_r = '0;
            rep_l = '0; rep_r = '0; zro_l = '0; zro_r = '0;
            exp_fs = 0; exp_ur = 0; acc_evt = 0;
        end else begin
            k++;
            ld  = is_load(k);
            acc = s_valid && !m_full;
            exp_fs = ld;
            exp_ur = ld && !m_full;
            if (ld) begin
                if (m_full) begin
                    rep_l = h_l; rep_r = h_r; zro_l = h_l; zro_r = h_r;
                    last_l = h_l; last_r = h_r; m_full = 0;
                end else begin
                    rep_l = last_l; rep_r = last_r; zro_l = '0; zro_r = '0;
                end
            end
            if (acc) begin
                h_l = s_left; h_r = s_right; m_full = 1;
            end
            acc_evt = acc;
        end
        mon_en = 1;
    end

    function automatic logic exp_bit(input int mode, input logic [SW-1:0] l,
                                     input logic [SW-1:0] r, input int b);
        int s;
        int ofs;
        logic [SW-1:0] smp;
        s   = b % SL;
        smp = (b < SL) ? l : r;
        ofs = (mode == 0) ? 1 : (mode == 1) ? 0 : SL - SW;
        if (s >= ofs && s < ofs + SW) return smp[SW-1-(s-ofs)];
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_inst(input int i);
        int            m;
        int            b;
        logic          e_dat, e_lrc;
        logic [SW-1:0] l, r;
        m = k / FALL_CYC;
        l = (i == 1) ? zro_l : rep_l;
        r = (i == 1) ? zro_r : rep_r;
        if (m == 0) begin
            e_dat = 1'b0;
            e_lrc = 1'b0;
        end else begin
            b     = (m - 1) % FB;
            e_lrc = (b >= SL);
            e_dat = exp_bit(i, l, r, b);
        end
        check($sformatf("bclk[%0d]", i),        bclk_o[i], ((k / BD) % 2) == 1);
        check($sformatf("s_ready[%0d]", i),     rdy[i],    !m_full);
        check($sformatf("frame_start[%0d]", i), fs[i],     exp_fs);
        check($sformatf("underrun[%0d]", i),    ur[i],     exp_ur);
        check($sformatf("daclrc[%0d]", i),      lrc[i],    e_lrc);
        check($sformatf("dacdat[%0d]", i),      dat[i],    e_dat);
    endtask

    always @(negedge sys_clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) check_inst(i);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Source keeps data stable while valid is high and unaccepted; new data only after an accept.
    task automatic stream(input int n_cyc, input bit rnd, input bit gaps,
                          input logic [SW-1:0] fl, input logic [SW-1:0] fr);
        if (!s_valid) begin
            s_left  = rnd ? SW'($urandom) : fl;
            s_right = rnd ? SW'($urandom) : fr;
            s_valid = 1'b1;
        end
        repeat (n_cyc) begin
            @(negedge sys_clk);
            if (acc_evt) begin
                s_left  = rnd ? SW'($urandom) : fl;
                s_right = rnd ? SW'($urandom) : fr;
                s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else if (!s_valid) begin
                s_valid = ($urandom_range(0, 1) == 1);
            end
        end
    endtask

    task automatic send_one(input logic [SW-1:0] l, input logic [SW-1:0] r);
        bit got = 0;
        s_valid = 1'b0;
        @(negedge sys_clk);
        s_left = l; s_right = r; s_valid = 1'b1;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            @(negedge sys_clk);
            got = acc_evt;
        end
        s_valid = 1'b0;
        check("send_one_accept", got, 1'b1);
    endtask

    initial begin
        bit found;

        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;

        // I2S-framed constant pattern, plus LJ/RJ placement of a single-bit-edge value.
        stream(3 * FRAME, 0, 0, 24'hA5A5A5, 24'h5A5A5A);
        stream(2 * FRAME, 0, 0, 24'h800001, 24'h800001);

        // Underrun: one sample, then nothing.
        send_one(24'hA5A5A5, 24'h5A5A5A);
        wait_cyc(3 * FRAME);

        // Backpressure with random data, then random valid gaps.
        stream(8 * FRAME, 1, 0, '0, '0);
        stream(3 * FRAME, 1, 1, '0, '0);

        // Accept coinciding with a load on an empty hold.
        s_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge sys_clk);
            found = !m_full && is_load(k + 1);
        end
        check("t5_reach_load", found, 1'b1);
        s_left = 24'h123456; s_right = 24'hFEDCBA; s_valid = 1'b1;
        @(negedge sys_clk);
        check("t5_underrun", ur[0], 1'b1);
        check("t5_frame_start", fs[0], 1'b1);
        check("t5_ready_low", rdy[0], 1'b0);
        s_valid = 1'b0;
        wait_cyc(2 * FRAME);

        // Reset mid-frame at bit_cnt 40 with hold full.
        stream(FRAME / 2, 1, 0, '0, '0);
        found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge sys_clk);
            if (acc_evt) begin
                s_left = SW'($urandom); s_right = SW'($urandom);
            end
            found = m_full && ((k / FALL_CYC) % FB == 40) && (k % FALL_CYC == 0);
        end
        check("t6_reach_bit40", found, 1'b1);
        reset = 1'b1;
        s_valid = 1'b0;
        @(negedge sys_clk);
        check("t6_rst_ready", rdy[0], 1'b1);
        check("t6_rst_dacdat", dat[0], 1'b0);
        check("t6_rst_daclrc", lrc[0], 1'b0);
        check("t6_rst_bclk", bclk_o[0], 1'b0);
        reset = 1'b0;
        wait_cyc(3);
        check("t6_no_fall_yet", fs[0], 1'b0);
        wait_cyc(1);
        check("t6_first_load", fs[0], 1'b1);
        check("t6_underrun", ur[0], 1'b1);
        wait_cyc(FRAME);
        stream(2 * FRAME, 1, 0, '0, '0);
        s_valid = 1'b0;
        wait_cyc(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
